// File: rtl/alu_datapath.sv
// Accumulator datapath: an operation register (OP), an operand register (A)
// and an accumulator (C) with Z/N/Cy/V flags. Three strobes drive it: one
// latches the operation, one latches the operand, and one commits the ALU
// result into C. A sticky error flag records any edge where more than one
// strobe was high.
module alu_datapath #(
   parameter int WIDTH = 8
) (
   input  logic             CLKb,
   input  logic             RSTb,
   input  logic             enALU,
   input  logic             enA,
   input  logic             enC,
   input  logic [2:0]       op_in,
   input  logic [WIDTH-1:0] D_in,
   output logic [WIDTH-1:0] A_out,
   output logic [WIDTH-1:0] C_out,
   output logic             Z,
   output logic             N,
   output logic             Cy,
   output logic             V,
   output logic             done,
   output logic             seq_err
);

   localparam int MSB = WIDTH - 1;

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_AND  = 3'b010,
      OP_OR   = 3'b011,
      OP_XOR  = 3'b100,
      OP_NOT  = 3'b101,
      OP_SHL  = 3'b110,
      OP_PASS = 3'b111
   } op_e;

   op_e              op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] c_q;

   // Result of the ALU and its flags, computed from the current registers.
   logic [WIDTH-1:0] r;
   logic             cy_nxt;
   logic             v_nxt;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic             multi_strobe;

   // One-bit-wider add and subtract: the extra bit is the carry out for ADD
   // and the borrow for SUB (it goes high exactly when C < A unsigned).
   assign sum  = {1'b0, c_q} + {1'b0, a_q};
   assign diff = {1'b0, c_q} - {1'b0, a_q};

   // Two or more strobes on the same edge is a sequencing violation.
   assign multi_strobe = (enA & enC) | (enA & enALU) | (enC & enALU);

   // ALU: select the result and compute carry/overflow for the current OP.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // through the case can leave one unassigned and infer a latch.
      r      = '0;
      cy_nxt = 1'b0;
      v_nxt  = 1'b0;
      case (op_q)
         OP_ADD: begin
            r      = sum[MSB:0];
            cy_nxt = sum[WIDTH];
            v_nxt  = (c_q[MSB] == a_q[MSB]) && (sum[MSB] != c_q[MSB]);
         end
         OP_SUB: begin
            r      = diff[MSB:0];
            cy_nxt = diff[WIDTH];
            v_nxt  = (c_q[MSB] != a_q[MSB]) && (diff[MSB] != c_q[MSB]);
         end
         OP_AND:  r = c_q & a_q;
         OP_OR:   r = c_q | a_q;
         OP_XOR:  r = c_q ^ a_q;
         OP_NOT:  r = ~a_q;
         OP_SHL: begin
            r      = {c_q[MSB-1:0], 1'b0};
            cy_nxt = c_q[MSB];
         end
         OP_PASS: r = a_q;
         default: r = '0;
      endcase
   end

   // Operation and operand registers load on their own strobes.
   always_ff @(posedge CLKb or negedge RSTb) begin
      // NOTE: every register here has a reset value, so the datapath comes
      // out of reset in a known state without any clock edge.
      if (!RSTb) begin
         op_q <= OP_ADD;
         a_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments mean every register samples the
         // pre-edge values, so a commit on the same edge as a new OP or A
         // still uses the old OP and A.
         if (enALU) op_q <= op_e'(op_in);
         if (enA)   a_q  <= D_in;
      end
   end

   // Accumulator and flags load together on a commit.
   always_ff @(posedge CLKb or negedge RSTb) begin
      if (!RSTb) begin
         c_q <= '0;
         Z   <= 1'b0;
         N   <= 1'b0;
         Cy  <= 1'b0;
         V   <= 1'b0;
      end else if (enC) begin
         c_q <= r;
         Z   <= (r == '0);
         N   <= r[MSB];
         Cy  <= cy_nxt;
         V   <= v_nxt;
      end
   end

   // done follows the commit strobe by one cycle; seq_err is sticky.
   always_ff @(posedge CLKb or negedge RSTb) begin
      if (!RSTb) begin
         done    <= 1'b0;
         seq_err <= 1'b0;
      end else begin
         done <= enC;
         if (multi_strobe) seq_err <= 1'b1;
      end
   end

   assign A_out = a_q;
   assign C_out = c_q;

endmodule

// File: tb/tb_alu_datapath.sv
// Self-checking bench for alu_datapath (WIDTH = 8): directed vectors for the
// documented scenarios followed by randomized strobes, data and resets, all
// compared against an integer-arithmetic reference model.
module tb_alu_datapath;

   localparam int W   = 8;
   localparam int M   = 2 ** W;
   localparam int HI  = M / 2;

   logic         CLKb;
   logic         RSTb;
   logic         enALU;
   logic         enA;
   logic         enC;
   logic [2:0]   op_in;
   logic [W-1:0] D_in;
   logic [W-1:0] A_out;
   logic [W-1:0] C_out;
   logic         Z;
   logic         N;
   logic         Cy;
   logic         V;
   logic         done;
   logic         seq_err;

   int tests_run = 0;
   int tests_failed = 0;

   // Reference model state.
   int m_op, m_a, m_c;
   int m_z, m_n, m_cy, m_v, m_done, m_err;

   alu_datapath #(.WIDTH(W)) dut (
      .CLKb    (CLKb),
      .RSTb    (RSTb),
      .enALU   (enALU),
      .enA     (enA),
      .enC     (enC),
      .op_in   (op_in),
      .D_in    (D_in),
      .A_out   (A_out),
      .C_out   (C_out),
      .Z       (Z),
      .N       (N),
      .Cy      (Cy),
      .V       (V),
      .done    (done),
      .seq_err (seq_err)
   );

   initial CLKb = 1'b0;
   always #5 CLKb = ~CLKb;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int sgn(input int x);
      return (x >= HI) ? x - M : x;
   endfunction

   // Result and flags from the arithmetic definition of each operation.
   task automatic ref_alu(input int op, input int a, input int c,
                          output int r, output int z, output int n,
                          output int cy, output int v);
      int s;
      r = 0; cy = 0; v = 0;
      case (op)
         0: begin
            s  = c + a;
            r  = s % M;
            cy = (s >= M);
            s  = sgn(c) + sgn(a);
            v  = (s >= HI) || (s < -HI);
         end
         1: begin
            r  = (c - a + M) % M;
            cy = (c < a);
            s  = sgn(c) - sgn(a);
            v  = (s >= HI) || (s < -HI);
         end
         2: r = c & a;
         3: r = c | a;
         4: r = c ^ a;
         5: r = (M - 1) - a;
         6: begin
            r  = (c * 2) % M;
            cy = (c >= HI);
         end
         default: r = a;
      endcase
      z = (r == 0);
      n = (r >= HI);
   endtask

   task automatic model_reset();
      m_op = 0; m_a = 0; m_c = 0;
      m_z = 0; m_n = 0; m_cy = 0; m_v = 0; m_done = 0; m_err = 0;
   endtask

   task automatic check_all(input string tag);
      check({tag, ".A"},   32'(A_out),   32'(m_a));
      check({tag, ".C"},   32'(C_out),   32'(m_c));
      check({tag, ".Z"},   32'(Z),       32'(m_z));
      check({tag, ".N"},   32'(N),       32'(m_n));
      check({tag, ".Cy"},  32'(Cy),      32'(m_cy));
      check({tag, ".V"},   32'(V),       32'(m_v));
      check({tag, ".done"},32'(done),    32'(m_done));
      check({tag, ".err"}, 32'(seq_err), 32'(m_err));
   endtask

   // One clock cycle with the given strobes; model updated from pre-edge state.
   task automatic step(input string tag, input logic s_alu, input logic s_a,
                       input logic s_c, input int op, input int d);
      int r, z, n, cy, v;
      @(negedge CLKb);
      enALU = s_alu; enA = s_a; enC = s_c;
      op_in = 3'(op); D_in = W'(d);
      @(posedge CLKb);
      ref_alu(m_op, m_a, m_c, r, z, n, cy, v);
      if (s_c) begin
         m_c = r; m_z = z; m_n = n; m_cy = cy; m_v = v;
      end
      if (s_alu) m_op = op;
      if (s_a)   m_a  = d;
      m_done = s_c;
      if (int'(s_alu) + int'(s_a) + int'(s_c) >= 2) m_err = 1;
      #1;
      check_all(tag);
   endtask

   // Reset dropped between edges; outputs must clear before the next edge,
   // and strobes held high during reset must be ignored.
   task automatic async_reset(input string tag);
      @(posedge CLKb);
      #2;
      RSTb = 1'b0;
      model_reset();
      #1;
      check_all({tag, ".imm"});
      enALU = 1'b1; enA = 1'b1; enC = 1'b1; D_in = 8'hA5; op_in = 3'd7;
      @(posedge CLKb);
      #1;
      check_all({tag, ".hold"});
      @(negedge CLKb);
      enALU = 1'b0; enA = 1'b0; enC = 1'b0;
      RSTb = 1'b1;
   endtask

   initial begin
      RSTb = 1'b0; enALU = 1'b0; enA = 1'b0; enC = 1'b0;
      op_in = '0; D_in = '0;
      model_reset();
      #2;
      check_all("rst");
      @(posedge CLKb);
      @(negedge CLKb);
      RSTb = 1'b1;

      // Pass 0x7F, then ADD 0x01: signed overflow into 0x80.
      step("p_op",  1, 0, 0, 7, 0);
      step("p_a",   0, 1, 0, 0, 8'h7F);
      step("p_c",   0, 0, 1, 0, 0);
      check("r31_c1", 32'(C_out), 32'h7F);
      step("add_op", 1, 0, 0, 0, 0);
      step("add_a",  0, 1, 0, 0, 8'h01);
      step("add_c",  0, 0, 1, 0, 0);
      check("r31_c", 32'(C_out), 32'h80);
      check("r31_nv", {30'd0, N, V}, 32'h3);
      step("add_idle", 0, 0, 0, 0, 0);
      check("r31_pulse", 32'(done), 32'h0);

      // ADD wrap: 0xFF + 0x01.
      step("w_op",  1, 0, 0, 7, 0);
      step("w_a",   0, 1, 0, 0, 8'hFF);
      step("w_c",   0, 0, 1, 0, 0);
      step("w_op2", 1, 0, 0, 0, 0);
      step("w_a2",  0, 1, 0, 0, 8'h01);
      step("w_c2",  0, 0, 1, 0, 0);
      check("r32_zcy", {30'd0, Z, Cy}, 32'h3);

      // SUB borrow: 0x00 - 0x01.
      step("s_op", 1, 0, 0, 1, 0);
      step("s_c",  0, 0, 1, 0, 0);
      check("r33_c", 32'(C_out), 32'hFF);

      // SHL of 0x81, back-to-back commits keep done high.
      step("h_op",  1, 0, 0, 7, 0);
      step("h_a",   0, 1, 0, 0, 8'h81);
      step("h_c",   0, 0, 1, 0, 0);
      step("h_op2", 1, 0, 0, 6, 0);
      step("h_c2",  0, 0, 1, 0, 0);
      check("r34_c", 32'(C_out), 32'h02);
      step("h_c3",  0, 0, 1, 0, 0);
      check("b2b_done", 32'(done), 32'h1);

      // Simultaneous enA + enC: commit uses old A.
      step("x_op",  1, 0, 0, 7, 0);
      step("x_a",   0, 1, 0, 0, 8'h10);
      step("x_c",   0, 0, 1, 0, 0);
      step("x_op2", 1, 0, 0, 0, 0);
      step("x_a2",  0, 1, 0, 0, 8'h05);
      step("x_both",0, 1, 1, 0, 8'h20);
      check("r35_c", 32'(C_out), 32'h15);
      check("r35_a", 32'(A_out), 32'h20);
      for (int i = 0; i < 4; i++) step("x_idle", 0, 0, 0, 0, 0);
      check("r35_sticky", 32'(seq_err), 32'h1);

      // Async reset with a pending operation: no commit, no done afterwards.
      step("q_op", 1, 0, 0, 7, 0);
      step("q_a",  0, 1, 0, 0, 8'h55);
      step("q_c",  0, 0, 1, 0, 0);
      step("q_op2",1, 0, 0, 0, 0);
      step("q_a2", 0, 1, 0, 0, 8'h33);
      async_reset("r36");
      step("q_post", 0, 0, 0, 0, 0);
      step("q_post2",0, 0, 0, 0, 0);

      // Randomized strobes, operations and data, with occasional resets.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 59) == 0) begin
            async_reset("rnd_rst");
         end else begin
            int sel;
            sel = $urandom_range(0, 15);
            step("rnd",
                 sel < 4,
                 (sel >= 4 && sel < 8),
                 (sel >= 8 && sel < 12),
                 int'($urandom_range(0, 7)),
                 int'($urandom_range(0, M - 1)));
            if (sel == 12) step("rnd_dual", 1, 1, 0, int'($urandom_range(0, 7)),
                                int'($urandom_range(0, M - 1)));
            if (sel == 13) step("rnd_dual2", 1, 0, 1, int'($urandom_range(0, 7)),
                                int'($urandom_range(0, M - 1)));
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
